// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline types: forwarding select encoding, shadow-pipeline entry, XZR index.
package legv8_pkg;

  localparam int unsigned LEGV8_REG_W = 5;
  localparam logic [LEGV8_REG_W-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                   valid;
    logic [LEGV8_REG_W-1:0] rd;
    logic                   reg_write;
    logic                   mem_read;
    logic                   set_flags;
  } pipe_entry_t;

endpackage

// File: rtl/hazard_controller_if.sv
// ID-stage usage in, sequencing/forwarding controls out. The ID stage is master, the controller slave.
interface hazard_controller_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
);
  logic             id_valid;
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_use_rn;
  logic             id_use_rm;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_set_flags;
  logic             id_read_flags;
  logic             id_cbz;
  logic             id_br_taken;

  logic             stall;
  logic             bubble;
  logic             flush_if;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             flag_fwd;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd, id_reg_write, id_mem_read,
           id_set_flags, id_read_flags, id_cbz, id_br_taken,
    input  stall, bubble, flush_if, fwd_a, fwd_b, flag_fwd, stall_cycles
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd, id_reg_write, id_mem_read,
           id_set_flags, id_read_flags, id_cbz, id_br_taken,
    output stall, bubble, flush_if, fwd_a, fwd_b, flag_fwd, stall_cycles
  );
endinterface

// File: rtl/hazard_pipe_tracker.sv
// Private EX/MEM/WB shadow of in-flight writers; a bubble or empty ID enters EX as an invalid entry.
module hazard_pipe_tracker
  import legv8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  pipe_entry_t id_entry,
  input  logic        insert_bubble,
  output pipe_entry_t ex_entry,
  output pipe_entry_t mem_entry,
  output pipe_entry_t wb_entry
);

  pipe_entry_t ex_q, mem_q, wb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= insert_bubble ? '0 : id_entry;
    end
  end

  assign ex_entry  = ex_q;
  assign mem_entry = mem_q;
  assign wb_entry  = wb_q;

endmodule

// File: rtl/hazard_controller.sv
// LEGv8 hazard unit: load-use/CBZ/flag stalls, IF flush, operand forwarding, stall-cycle counter.
// Build option: HAZARD_FLAG_FWD_EN forwards EX-stage flags to B.cond instead of stalling.
module hazard_controller
  import legv8_pkg::*;
#(
  parameter int unsigned REG_W    = LEGV8_REG_W,
  parameter int unsigned ZERO_REG = 32'(XZR),
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_controller_if.slave hz
);

  localparam logic [REG_W-1:0] ZeroIdx = REG_W'(ZERO_REG);

  pipe_entry_t id_entry, ex_entry, mem_entry, unused_wb_entry;
  logic        unused_mem_flags;
  logic        load_use, cbz_haz, flag_haz, stall_raw, stall, flag_fwd;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  function automatic logic match(pipe_entry_t e, logic [REG_W-1:0] r);
    return e.valid && e.reg_write && (e.rd == r) && (r != ZeroIdx);
  endfunction

  function automatic fwd_sel_e fwd_sel(logic [REG_W-1:0] r);
    if (match(ex_entry, r))       return FWD_EX;
    else if (match(mem_entry, r)) return FWD_MEM;
    else                          return FWD_RF;
  endfunction

  assign id_entry = '{valid:     hz.id_valid,
                      rd:        hz.id_rd,
                      reg_write: hz.id_reg_write,
                      mem_read:  hz.id_mem_read,
                      set_flags: hz.id_set_flags};

  hazard_pipe_tracker u_tracker (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_entry      (id_entry),
    .insert_bubble (stall | ~hz.id_valid),
    .ex_entry      (ex_entry),
    .mem_entry     (mem_entry),
    .wb_entry      (unused_wb_entry)
  );

  assign unused_mem_flags = mem_entry.set_flags;

  always_comb begin
    load_use = ex_entry.mem_read &&
               ((hz.id_use_rn && match(ex_entry, hz.id_rn)) ||
                (hz.id_use_rm && match(ex_entry, hz.id_rm)));
    // CBZ compares in ID, so it waits until the writer has reached WB (regfile write-first).
    cbz_haz  = hz.id_cbz && (match(ex_entry, hz.id_rm) || match(mem_entry, hz.id_rm));
    flag_haz = hz.id_read_flags && ex_entry.valid && ex_entry.set_flags;
`ifdef HAZARD_FLAG_FWD_EN
    stall_raw = hz.id_valid && (load_use || cbz_haz);
    flag_fwd  = rst_n && hz.id_valid && flag_haz && !stall_raw;
`else
    stall_raw = hz.id_valid && (load_use || cbz_haz || flag_haz);
    flag_fwd  = 1'b0;
`endif
    // Outputs are combinational, so gate them directly while reset is held.
    stall = rst_n && stall_raw;
  end

  assign hz.stall    = stall;
  assign hz.bubble   = stall;
  assign hz.flush_if = rst_n && hz.id_valid && hz.id_br_taken && !stall;
  assign hz.flag_fwd = flag_fwd;
  assign hz.fwd_a    = (rst_n && hz.id_valid && !stall && hz.id_use_rn) ? fwd_sel(hz.id_rn) : FWD_RF;
  assign hz.fwd_b    = (rst_n && hz.id_valid && !stall && hz.id_use_rm) ? fwd_sel(hz.id_rm) : FWD_RF;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign hz.stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed ID vectors, expectations queued, checked at negedge.
module tb_hazard_controller;

  typedef struct packed {
    logic       v;
    logic [4:0] rn, rm, rd;
    logic       urn, urm, rw, mr, sf, rf, cbz, br;
  } id_t;

  typedef struct packed {
    logic       stall, bubble, flush;
    logic [1:0] fa, fb;
    logic       ff;
    logic [3:0] cnt;
  } exp_t;

`ifdef HAZARD_FLAG_FWD_EN
  localparam int   F  = 0;
  localparam logic FS = 1'b0;
  localparam logic FF = 1'b1;
`else
  localparam int   F  = 1;
  localparam logic FS = 1'b1;
  localparam logic FF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  hazard_controller_if #(.REG_W(5), .CNT_W(4)) hz ();

  hazard_controller #(.CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  function automatic id_t alu(int rd, int rn, int rm, logic urm, logic sf);
    id_t i = '0;
    i.v = 1; i.rd = 5'(rd); i.rn = 5'(rn); i.rm = 5'(rm); i.urn = 1; i.urm = urm;
    i.rw = 1; i.sf = sf;
    return i;
  endfunction

  function automatic id_t ldur(int rd, int rn);
    id_t i = '0;
    i.v = 1; i.rd = 5'(rd); i.rn = 5'(rn); i.urn = 1; i.rw = 1; i.mr = 1;
    return i;
  endfunction

  function automatic id_t cbz(int rt, logic taken);
    id_t i = '0;
    i.v = 1; i.rm = 5'(rt); i.urm = 1; i.cbz = 1; i.br = taken;
    return i;
  endfunction

  function automatic id_t bcond();
    id_t i = '0;
    i.v = 1; i.rf = 1;
    return i;
  endfunction

  // Invalid slot carrying junk that would otherwise flush and forward.
  function automatic id_t nop();
    id_t i = '0;
    i.rn = 5'd7; i.rm = 5'd7; i.urn = 1; i.urm = 1; i.br = 1; i.rw = 1; i.rd = 5'd2;
    return i;
  endfunction

  function automatic exp_t ex(logic st, logic fl, int fa, int fb, logic ff, int cnt);
    exp_t e;
    e.stall = st; e.bubble = st; e.flush = fl; e.fa = 2'(fa); e.fb = 2'(fb); e.ff = ff;
    e.cnt = 4'(cnt);
    return e;
  endfunction

  task automatic step(input id_t i, input exp_t e, input string nm, input logic rst);
    @(posedge clk);
    #1;
    rst_n            = rst;
    hz.id_valid      = i.v;
    hz.id_rn         = i.rn;
    hz.id_rm         = i.rm;
    hz.id_rd         = i.rd;
    hz.id_use_rn     = i.urn;
    hz.id_use_rm     = i.urm;
    hz.id_reg_write  = i.rw;
    hz.id_mem_read   = i.mr;
    hz.id_set_flags  = i.sf;
    hz.id_read_flags = i.rf;
    hz.id_cbz        = i.cbz;
    hz.id_br_taken   = i.br;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin : monitor
    exp_t  e;
    exp_t  g;
    string nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g  = {hz.stall, hz.bubble, hz.flush_if, hz.fwd_a, hz.fwd_b, hz.flag_fwd, hz.stall_cycles};
      n_tests++;
      if (g !== e)begin
        n_fail++;
        $display("FAIL %s: got stall=%b bub=%b flush=%b fa=%b fb=%b ff=%b cnt=%0d, exp stall=%b bub=%b flush=%b fa=%b fb=%b ff=%b cnt=%0d",
                 nm, g.stall, g.bubble, g.flush, g.fa, g.fb, g.ff, g.cnt,
                 e.stall, e.bubble, e.flush, e.fa, e.fb, e.ff, e.cnt);
      end
    end
  end

  initial begin
    int c;
    step(cbz(1, 1), ex(0, 0, 0, 0, 0, 0), "reset_idle", 1'b0);
    step(ldur(1, 2), ex(0, 0, 0, 0, 0, 0), "ldur_issue", 1'b1);
    step(alu(3, 1, 4, 1, 0), ex(1, 0, 0, 0, 0, 0), "load_use_stall", 1'b1);
    step(alu(3, 1, 4, 1, 0), ex(0, 0, 2, 0, 0, 1), "load_use_fwd_mem", 1'b1);
    step(alu(1, 2, 3, 1, 1), ex(0, 0, 0, 1, 0, 1), "adds_fwd_b_ex", 1'b1);
    step(alu(5, 1, 1, 1, 1), ex(0, 0, 1, 1, 0, 1), "subs_fwd_both_ex", 1'b1);
    step(alu(31, 2, 0, 0, 0), ex(0, 0, 0, 0, 0, 1), "addi_xzr", 1'b1);
    step(alu(6, 31, 31, 1, 0), ex(0, 0, 0, 0, 0, 1), "xzr_no_fwd", 1'b1);
    step(alu(1, 2, 3, 1, 1), ex(0, 0, 0, 0, 0, 1), "subs_issue", 1'b1);
    step(bcond(), ex(FS, 0, 0, 0, FF, 1), "bcond_flag_hazard", 1'b1);
    step(bcond(), ex(0, 0, 0, 0, 0, 1 + F), "bcond_after", 1'b1);
    step(alu(1, 2, 3, 1, 0), ex(0, 0, 0, 0, 0, 1 + F), "add_issue", 1'b1);
    step(cbz(1, 1), ex(1, 0, 0, 0, 0, 1 + F), "cbz_stall_ex", 1'b1);
    step(cbz(1, 1), ex(1, 0, 0, 0, 0, 2 + F), "cbz_stall_mem", 1'b1);
    step(cbz(1, 1), ex(0, 1, 0, 0, 0, 3 + F), "cbz_flush_once", 1'b1);
    step(nop(), ex(0, 0, 0, 0, 0, 3 + F), "invalid_id", 1'b1);
    step(alu(7, 2, 3, 1, 0), ex(0, 0, 0, 0, 0, 3 + F), "add7_a", 1'b1);
    step(alu(7, 7, 2, 1, 0), ex(0, 0, 1, 0, 0, 3 + F), "add7_b_fwd_ex", 1'b1);
    step(alu(8, 7, 7, 1, 0), ex(0, 0, 1, 1, 0, 3 + F), "ex_beats_mem", 1'b1);
    step(alu(9, 2, 7, 1, 0), ex(0, 0, 0, 2, 0, 3 + F), "fwd_b_mem", 1'b1);
    step(ldur(4, 2), ex(0, 0, 0, 0, 0, 3 + F), "ldur4", 1'b1);
    step(cbz(4, 0), ex(1, 0, 0, 0, 0, 3 + F), "cbz_ldur_ex", 1'b1);
    step(cbz(4, 0), ex(1, 0, 0, 0, 0, 4 + F), "cbz_ldur_mem", 1'b1);
    step(cbz(4, 0), ex(0, 0, 0, 0, 0, 5 + F), "cbz_not_taken", 1'b1);
    step(ldur(5, 2), ex(0, 0, 0, 0, 0, 5 + F), "ldur5", 1'b1);
    step(alu(6, 2, 5, 1, 0), ex(1, 0, 0, 0, 0, 5 + F), "load_use_rm", 1'b1);
    step(alu(6, 2, 5, 1, 0), ex(0, 0, 0, 2, 0, 6 + F), "load_use_rm_fwd", 1'b1);
    step(ldur(10, 2), ex(0, 0, 0, 0, 0, 6 + F), "ldur10", 1'b1);
    step(cbz(10, 1), ex(1, 0, 0, 0, 0, 6 + F), "pre_reset_stall", 1'b1);
    step(cbz(10, 1), ex(0, 0, 0, 0, 0, 0), "reset_mid_stall", 1'b0);
    step(cbz(10, 1), ex(0, 1, 0, 0, 0, 0), "post_reset_clean", 1'b1);
    c = 0;
    for (int k = 0; k < 9; k++) begin
      step(alu(1, 2, 3, 1, 0), ex(0, 0, 0, 0, 0, c), "sat_add", 1'b1);
      step(cbz(1, 0), ex(1, 0, 0, 0, 0, c), "sat_stall1", 1'b1);
      c = (c < 15) ? c + 1 : 15;
      step(cbz(1, 0), ex(1, 0, 0, 0, 0, c), "sat_stall2", 1'b1);
      c = (c < 15) ? c + 1 : 15;
      step(cbz(1, 0), ex(0, 0, 0, 0, 0, c), "sat_go", 1'b1);
    end
    repeat (2) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
